stim_resp_sequencer: RTL and testbench
======================================

STIM_RESP_SEQUENCER -- requirements
Module: stim_resp_sequencer

Interface
REQ-001 Parameter NPAT, default 256: patterns per run, legal range 1..65535.
REQ-002 Parameter SEED, default 14'h2A5B: LFSR start value, must be nonzero.
REQ-003 Parameter GOLDEN, default 16'h0000: expected final signature, used only under GOLDEN_CMP_EN.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a run; sampled only in IDLE.
REQ-007 pat_o  output  14  stimulus driven to the combinational netlist inputs.
REQ-008 pat_vld  output  1  pat_o is a valid pattern this cycle.
REQ-009 resp_i  input  8  netlist outputs, combinationally derived from pat_o in the same cycle.
REQ-010 busy  output  1  run in progress.
REQ-011 done  output  1  one-cycle pulse at end of run.
REQ-012 sig_o  output  16  MISR signature.
REQ-013 pass_o  output  1  signature match flag; present only under GOLDEN_CMP_EN.

Function
REQ-014 FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE on the edge where pattern count equals NPAT-1; DONE->IDLE unconditionally after one cycle.
REQ-015 On the IDLE->RUN edge the LFSR loads SEED, the MISR loads 16'h0000 and the 16-bit counter loads 0.
REQ-016 In RUN, busy=1 and pat_vld=1 every cycle, and pat_o equals the LFSR value; outside RUN, busy=0, pat_vld=0 and pat_o=0.
REQ-017 LFSR is Fibonacci, polynomial x^14+x^13+x^12+x^2+1: next = {lfsr[12:0], lfsr[13]^lfsr[12]^lfsr[11]^lfsr[1]}, advanced once per RUN cycle.
REQ-018 MISR is polynomial x^16+x^15+x^13+x^4+1: next = {sig[14:0], sig[15]^sig[14]^sig[12]^sig[3]} XOR {8'h00, resp_i}, updated once per RUN cycle.
REQ-019 The MISR samples resp_i at the same edge that advances pat_o, so each response is paired with the pattern it was derived from; latency is zero cycles.
REQ-020 The counter increments once per RUN cycle, and exactly NPAT patterns are issued per run.
REQ-021 start during RUN or DONE is ignored, and it does not queue a run.
REQ-022 start held high continuously causes back-to-back runs, separated by one DONE cycle and one IDLE cycle.
REQ-023 done=1 only in the DONE state; sig_o holds its final value from DONE until the next IDLE->RUN edge.
REQ-024 NPAT=1 yields a single RUN cycle followed by DONE.

Reset
REQ-025 rst=1 at any edge, including mid-run, forces IDLE; the LFSR returns to SEED, and counter, sig_o, pass_o, busy, done, pat_vld and pat_o return to 0.
REQ-026 rst has priority over start in the same cycle.

Configuration
REQ-027 Macro GOLDEN_CMP_EN defined: pass_o is registered and loaded at the RUN->DONE edge with (final signature == GOLDEN); it holds that value until the next IDLE->RUN edge, where it clears to 0.
REQ-028 Macro GOLDEN_CMP_EN undefined: the pass_o port and the comparator are absent, and all other behaviour is identical.

Verification
REQ-029 NPAT=1, resp_i=8'h00, pulse start: busy=1 and pat_o=14'h2A5B for exactly 1 cycle -> done pulse, sig_o=16'h0000.
REQ-030 NPAT=2, resp_i=8'h01 held: pat_o sequence 14'h2A5B then 14'h14B7 -> final sig_o=16'h0003.
REQ-031 NPAT=256, start at edge k: busy high on cycles k+1..k+256, done on cycle k+257, 256 pat_vld cycles total.
REQ-032 Assert rst during pattern 100 of a run -> next cycle is IDLE with all outputs 0; a later start reproduces the same signature as an uninterrupted run.
REQ-033 GOLDEN_CMP_EN, NPAT=2, resp_i=8'h01, GOLDEN=16'h0003 -> pass_o=1 at done; repeat with GOLDEN=16'h0004 -> pass_o=0.
REQ-034 start pulsed mid-run and start held high -> no extra patterns issued mid-run; with start held, runs restart after one DONE cycle and one IDLE cycle.

Source files
------------

// File: rtl/stim_resp_sequencer.sv
// LFSR stimulus generator with MISR response compaction for a combinational netlist under test.
// Optional macro GOLDEN_CMP_EN adds a registered pass_o flag comparing the final signature to GOLDEN.
module stim_resp_sequencer #(
  parameter int          NPAT   = 256,
  parameter logic [13:0] SEED   = 14'h2A5B,
  parameter logic [15:0] GOLDEN = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [13:0] pat_o,
  output logic        pat_vld,
  input  logic [7:0]  resp_i,
  output logic        busy,
  output logic        done,
  output logic [15:0] sig_o
`ifdef GOLDEN_CMP_EN
  ,
  output logic        pass_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(NPAT - 1);

  // Fibonacci LFSR, x^14+x^13+x^12+x^2+1
  function automatic logic [13:0] lfsr_step(input logic [13:0] v);
    return {v[12:0], v[13] ^ v[12] ^ v[11] ^ v[1]};
  endfunction

  // MISR, x^16+x^15+x^13+x^4+1, folding in one 8-bit response
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] r);
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {8'h00, r};
  endfunction

  state_t      state_r, state_nxt_s;
  logic [13:0] lfsr_r, lfsr_nxt_s;
  logic [15:0] sig_r, sig_nxt_s;
  logic [15:0] cnt_r, cnt_nxt_s;
  logic [13:0] pat_r;
  logic        pat_vld_r;
  logic        busy_r;
  logic        done_r;

  // Next-state, LFSR, MISR and counter update
  always_comb begin
    state_nxt_s = state_r;
    lfsr_nxt_s  = lfsr_r;
    sig_nxt_s   = sig_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
          lfsr_nxt_s  = SEED;
          sig_nxt_s   = 16'h0000;
          cnt_nxt_s   = 16'h0000;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        // resp_i belongs to the pattern currently on pat_o, so it is folded in at this edge
        lfsr_nxt_s = lfsr_step(lfsr_r);
        sig_nxt_s  = misr_step(sig_r, resp_i);
        cnt_nxt_s  = cnt_r + 16'd1;
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      lfsr_r  <= SEED;
      sig_r   <= 16'h0000;
      cnt_r   <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      lfsr_r  <= lfsr_nxt_s;
      sig_r   <= sig_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Output registers, loaded from the next state so they line up with state_r
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r     <= 14'h0000;
      pat_vld_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      pat_r     <= (state_nxt_s == RUN) ? lfsr_nxt_s : 14'h0000;
      pat_vld_r <= (state_nxt_s == RUN);
      busy_r    <= (state_nxt_s == RUN);
      done_r    <= (state_nxt_s == DONE);
    end
  end

  assign pat_o   = pat_r;
  assign pat_vld = pat_vld_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign sig_o   = sig_r;

`ifdef GOLDEN_CMP_EN
  logic pass_r, pass_nxt_s;

  // Pass flag: cleared at run start, captured from the final signature at run end
  always_comb begin
    pass_nxt_s = pass_r;
    if ((state_r == IDLE) && (state_nxt_s == RUN)) begin
      pass_nxt_s = 1'b0;
    end else if ((state_r == RUN) && (state_nxt_s == DONE)) begin
      pass_nxt_s = (sig_nxt_s == GOLDEN);
    end else begin
      pass_nxt_s = pass_r;
    end
  end

  // Pass flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_r <= 1'b0;
    end else begin
      pass_r <= pass_nxt_s;
    end
  end

  assign pass_o = pass_r;
`else
  logic unused_golden_s;
  assign unused_golden_s = ^GOLDEN;
`endif

endmodule

// File: tb/tb_stim_resp_sequencer.sv
// Self-checking bench for stim_resp_sequencer: NPAT=1, NPAT=2 and NPAT=256 instances driven by a
// randomized combinational "netlist" and checked against a loop-based signature model.
module tb_stim_resp_sequencer;

  localparam logic [13:0] SEED = 14'h2A5B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start1, start2, start3;
  logic [13:0] pat1, pat2, pat3;
  logic        vld1, vld2, vld3;
  logic        busy1, busy2, busy3;
  logic        done1, done2, done3;
  logic [15:0] sig1, sig2, sig3;
  logic [7:0]  resp1, resp2, resp3;
  logic [7:0]  mask, konst;

  int checks = 0;
  int errors = 0;

  // Device under test model: responses depend only on the pattern currently applied
  function automatic logic [7:0] netlist(input logic [13:0] p, input logic [7:0] m, input logic [7:0] k);
    return ((p[7:0] ^ p[13:6]) & m) ^ k;
  endfunction

  assign resp1 = netlist(pat1, mask, konst);
  assign resp2 = netlist(pat2, mask, konst);
  assign resp3 = netlist(pat3, mask, konst);

`ifdef GOLDEN_CMP_EN
  logic        pass1, pass2, pass3, pass2b;
  logic [13:0] pat2b;
  logic        vld2b, busy2b, done2b;
  logic [15:0] sig2b;
  logic [7:0]  resp2b;
  assign resp2b = netlist(pat2b, mask, konst);

  stim_resp_sequencer #(.NPAT(2), .GOLDEN(16'h0004)) u2b (
    .clk(clk), .rst(rst), .start(start2), .pat_o(pat2b), .pat_vld(vld2b), .resp_i(resp2b),
    .busy(busy2b), .done(done2b), .sig_o(sig2b), .pass_o(pass2b));
`endif

  stim_resp_sequencer #(.NPAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .pat_o(pat1), .pat_vld(vld1), .resp_i(resp1),
    .busy(busy1), .done(done1), .sig_o(sig1)
`ifdef GOLDEN_CMP_EN
    , .pass_o(pass1)
`endif
  );

  stim_resp_sequencer #(.NPAT(2), .GOLDEN(16'h0003)) u2 (
    .clk(clk), .rst(rst), .start(start2), .pat_o(pat2), .pat_vld(vld2), .resp_i(resp2),
    .busy(busy2), .done(done2), .sig_o(sig2)
`ifdef GOLDEN_CMP_EN
    , .pass_o(pass2)
`endif
  );

  stim_resp_sequencer u3 (
    .clk(clk), .rst(rst), .start(start3), .pat_o(pat3), .pat_vld(vld3), .resp_i(resp3),
    .busy(busy3), .done(done3), .sig_o(sig3)
`ifdef GOLDEN_CMP_EN
    , .pass_o(pass3)
`endif
  );

  // Reference: polynomial taps as masks, feedback is the parity of the tapped bits
  function automatic logic [13:0] model_lfsr(input logic [13:0] v);
    return {v[12:0], ^(v & 14'h3802)};
  endfunction

  function automatic logic [15:0] model_misr(input logic [15:0] s, input logic [7:0] r);
    return {s[14:0], ^(s & 16'hD008)} ^ {8'h00, r};
  endfunction

  function automatic logic [15:0] model_signature(input int n);
    logic [13:0] p;
    logic [15:0] s;
    p = SEED;
    s = 16'h0000;
    for (int i = 0; i < n; i++) begin
      s = model_misr(s, netlist(p, mask, konst));
      p = model_lfsr(p);
    end
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    mask = 8'h00; konst = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy3); end
    checks++; if (vld3 !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", vld3); end
    checks++; if (pat3 !== 14'h0000) begin errors++; $display("FAIL reset_pat got %h exp 0000", pat3); end
    checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done3); end
    checks++; if (sig3 !== 16'h0000) begin errors++; $display("FAIL reset_sig got %h exp 0000", sig3); end
    checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy12 got %b%b exp 00", busy1, busy2); end
`ifdef GOLDEN_CMP_EN
    checks++; if (pass2 !== 1'b0) begin errors++; $display("FAIL reset_pass got %b exp 0", pass2); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_npat1();
    mask = 8'h00; konst = 8'h00;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++; if (busy1 !== 1'b1 || pat1 !== SEED) begin errors++; $display("FAIL npat1_run got busy=%b pat=%h exp 1 %h", busy1, pat1, SEED); end
    @(negedge clk);
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b1) begin errors++; $display("FAIL npat1_done got busy=%b done=%b exp 0 1", busy1, done1); end
    checks++; if (sig1 !== 16'h0000) begin errors++; $display("FAIL npat1_sig got %h exp 0000", sig1); end
    @(negedge clk);
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL npat1_idle got busy=%b done=%b exp 0 0", busy1, done1); end
  endtask

  task automatic test_npat2();
    mask = 8'h00; konst = 8'h01;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    checks++; if (pat2 !== 14'h2A5B || vld2 !== 1'b1) begin errors++; $display("FAIL npat2_pat0 got %h vld=%b exp 2a5b 1", pat2, vld2); end
`ifdef GOLDEN_CMP_EN
    checks++; if (pass2 !== 1'b0) begin errors++; $display("FAIL npat2_pass_run got %b exp 0", pass2); end
`endif
    @(negedge clk);
    checks++; if (pat2 !== 14'h14B7 || busy2 !== 1'b1) begin errors++; $display("FAIL npat2_pat1 got %h busy=%b exp 14b7 1", pat2, busy2); end
    @(negedge clk);
    checks++; if (done2 !== 1'b1 || busy2 !== 1'b0 || vld2 !== 1'b0) begin errors++; $display("FAIL npat2_done got done=%b busy=%b vld=%b exp 1 0 0", done2, busy2, vld2); end
    checks++; if (sig2 !== 16'h0003) begin errors++; $display("FAIL npat2_sig got %h exp 0003", sig2); end
`ifdef GOLDEN_CMP_EN
    checks++; if (pass2 !== 1'b1) begin errors++; $display("FAIL golden_match got %b exp 1", pass2); end
    checks++; if (pass2b !== 1'b0) begin errors++; $display("FAIL golden_miss got %b exp 0", pass2b); end
`endif
    @(negedge clk);
    checks++; if (sig2 !== 16'h0003 || done2 !== 1'b0 || pat2 !== 14'h0000) begin errors++; $display("FAIL npat2_hold got sig=%h done=%b pat=%h exp 0003 0 0000", sig2, done2, pat2); end
  endtask

  // One complete NPAT=256 run on u3 with a stray start pulse somewhere mid-run
  task automatic full_run(input int tag);
    logic [13:0] exp_pat;
    logic [15:0] exp_sig;
    int c, nbusy, nvld, mism, pulse_at;
    exp_sig = model_signature(256);
    exp_pat = SEED;
    nbusy = 0; nvld = 0; mism = 0; c = 0;
    pulse_at = $urandom_range(10, 200);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    while (c < 300 && done3 !== 1'b1) begin
      if (busy3 === 1'b1) begin
        if (pat3 !== exp_pat) mism++;
        exp_pat = model_lfsr(exp_pat);
        nbusy++;
      end
      if (vld3 === 1'b1) nvld++;
      start3 = (nbusy == pulse_at);
      @(negedge clk);
      c++;
    end
    start3 = 1'b0;
    checks++; if (c != 256) begin errors++; $display("FAIL run%0d_done_cycle got %0d exp 256", tag, c); end
    checks++; if (nbusy != 256 || nvld != 256) begin errors++; $display("FAIL run%0d_count got busy=%0d vld=%0d exp 256", tag, nbusy, nvld); end
    checks++; if (mism != 0) begin errors++; $display("FAIL run%0d_patterns got %0d wrong exp 0", tag, mism); end
    checks++; if (sig3 !== exp_sig) begin errors++; $display("FAIL run%0d_sig got %h exp %h", tag, sig3, exp_sig); end
    @(negedge clk);
    checks++; if (busy3 !== 1'b0 || done3 !== 1'b0) begin errors++; $display("FAIL run%0d_no_queue got busy=%b done=%b exp 0 0", tag, busy3, done3); end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 3; r++) begin
      mask = 8'($urandom); konst = 8'($urandom);
      full_run(r);
    end
  endtask

  task automatic test_reset_midrun();
    int c, nbusy;
    mask = 8'($urandom); konst = 8'($urandom);
    c = 0; nbusy = 0;
    start3 = 1'b1;
    while (c < 300 && nbusy < 100) begin
      @(negedge clk);
      start3 = 1'b0;
      c++;
      if (busy3 === 1'b1) nbusy++;
    end
    checks++; if (nbusy != 100) begin errors++; $display("FAIL midrun_reach got %0d exp 100", nbusy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy3 !== 1'b0 || vld3 !== 1'b0 || done3 !== 1'b0) begin errors++; $display("FAIL midrun_ctrl got busy=%b vld=%b done=%b exp 0 0 0", busy3, vld3, done3); end
    checks++; if (pat3 !== 14'h0000 || sig3 !== 16'h0000) begin errors++; $display("FAIL midrun_data got pat=%h sig=%h exp 0000 0000", pat3, sig3); end
    @(negedge clk);
    full_run(9);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_sig;
    int c, nbusy;
    mask = 8'($urandom); konst = 8'($urandom);
    exp_sig = model_signature(256);
    start3 = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      nbusy = 0; c = 0;
      while (c < 300 && done3 !== 1'b1) begin
        if (busy3 === 1'b1) nbusy++;
        @(negedge clk);
        c++;
      end
      checks++; if (nbusy != 256) begin errors++; $display("FAIL b2b%0d_count got %0d exp 256", r, nbusy); end
      checks++; if (sig3 !== exp_sig) begin errors++; $display("FAIL b2b%0d_sig got %h exp %h", r, sig3, exp_sig); end
      @(negedge clk);
      checks++; if (busy3 !== 1'b0 || done3 !== 1'b0) begin errors++; $display("FAIL b2b%0d_idle got busy=%b done=%b exp 0 0", r, busy3, done3); end
      @(negedge clk);
      checks++; if (busy3 !== 1'b1 || pat3 !== SEED) begin errors++; $display("FAIL b2b%0d_restart got busy=%b pat=%h exp 1 %h", r, busy3, pat3, SEED); end
    end
    start3 = 1'b0;
    c = 0;
    while (c < 300 && done3 !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    checks++; if (done3 !== 1'b1) begin errors++; $display("FAIL b2b_drain got done=%b exp 1", done3); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_npat1();
    test_npat2();
    test_random_runs();
    test_reset_midrun();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
